// File: rtl/cmp_pkg.sv
// -----------------------------------------------------------------------------
// cmp_pkg
// Shared definitions for the serial comparator controller:
//   state_t          - controller state encoding (IDLE / RUN / DONE)
//   GT_RST/EQ_RST/LT_RST - seed and reset values of the compare flags
//                      ("equal so far" is the neutral starting point)
// -----------------------------------------------------------------------------
package cmp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic GT_RST = 1'b0;
   localparam logic EQ_RST = 1'b1;
   localparam logic LT_RST = 1'b0;

endpackage

// File: rtl/one_bit_comparator.sv
// -----------------------------------------------------------------------------
// one_bit_comparator
// One magnitude-compare cell for an MSB-first chain. While the more
// significant bits were equal (eq_in) this bit decides; once a decision has
// been made higher up it is passed through unchanged.
// Ports:
//   a, b                 in  - operand bits at the current position
//   gt_in, eq_in, lt_in  in  - flags from the more significant positions
//   gt, eq, lt           out - flags including this position
// -----------------------------------------------------------------------------
module one_bit_comparator (
   input  logic a,
   input  logic b,
   input  logic gt_in,
   input  logic eq_in,
   input  logic lt_in,
   output logic gt,
   output logic eq,
   output logic lt
);

   // Resolve this bit only when everything above it was equal
   always_comb begin
      gt = gt_in;
      eq = eq_in;
      lt = lt_in;
      if (eq_in) begin
         gt = a & ~b;
         eq = ~(a ^ b);
         lt = ~a & b;
      end else begin
         gt = gt_in;
         eq = 1'b0;
         lt = lt_in;
      end
   end

endmodule

// File: rtl/serial_compare_ctrl.sv
// -----------------------------------------------------------------------------
// serial_compare_ctrl
// Compares two WIDTH-bit operands one bit per cycle (MSB first) through a
// single one_bit_comparator cell. A start/done handshake frames each compare;
// with EARLY_EXIT set the compare finishes on the first differing bit.
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      synchronous active-low reset
//   start  in   1      compare request, only honoured while idle
//   a, b   in   WIDTH  operands, latched when start is accepted
//   busy   out  1      high in RUN and DONE
//   done   out  1      single-cycle result-valid pulse
//   agb    out  1      a > b   (held until the next compare finishes)
//   aeb    out  1      a == b
//   alb    out  1      a < b
//   steps  out  CW     bit steps used by the compare
// -----------------------------------------------------------------------------
module serial_compare_ctrl
   import cmp_pkg::*;
#(
   parameter  int WIDTH      = 8,
   parameter  bit EARLY_EXIT = 1'b1,
   localparam int CW         = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             agb,
   output logic             aeb,
   output logic             alb,
   output logic [CW-1:0]    steps
);

   localparam int           IW      = $clog2(WIDTH);
   localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);

   state_t           state_r;
   state_t           state_nxt_s;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [IW-1:0]    idx_r;
   logic [CW-1:0]    steps_r;
   logic             gt_r;
   logic             eq_r;
   logic             lt_r;
   logic             agb_r;
   logic             aeb_r;
   logic             alb_r;
   logic             busy_r;
   logic             done_r;
   logic             gt_s;
   logic             eq_s;
   logic             lt_s;
   logic             exit_s;

   // The single datapath cell, fed by the current bit and the chained flags
   one_bit_comparator u_cell (
      .a     (a_r[idx_r]),
      .b     (b_r[idx_r]),
      .gt_in (gt_r),
      .eq_in (eq_r),
      .lt_in (lt_r),
      .gt    (gt_s),
      .eq    (eq_s),
      .lt    (lt_s)
   );

   // Last step: LSB reached, or an early decision once bits differ
   always_comb begin
      exit_s = 1'b0;
      if ((idx_r == {IW{1'b0}}) || (EARLY_EXIT && !eq_s)) begin
         exit_s = 1'b1;
      end else begin
         exit_s = 1'b0;
      end
   end

   // Next-state decode for the IDLE -> RUN -> DONE sequence
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RUN: begin
            if (exit_s) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = RUN;
            end
         end
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // State, counters, chained flags and registered host outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
         a_r     <= {WIDTH{1'b0}};
         b_r     <= {WIDTH{1'b0}};
         idx_r   <= IDX_MSB;
         steps_r <= {CW{1'b0}};
         gt_r    <= GT_RST;
         eq_r    <= EQ_RST;
         lt_r    <= LT_RST;
         agb_r   <= GT_RST;
         aeb_r   <= EQ_RST;
         alb_r   <= LT_RST;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         busy_r  <= (state_nxt_s != IDLE);
         done_r  <= (state_nxt_s == DONE);
         case (state_r)
            IDLE: begin
               if (start) begin
                  a_r     <= a;
                  b_r     <= b;
                  idx_r   <= IDX_MSB;
                  steps_r <= {CW{1'b0}};
                  gt_r    <= GT_RST;
                  eq_r    <= EQ_RST;
                  lt_r    <= LT_RST;
               end
            end
            RUN: begin
               gt_r    <= gt_s;
               eq_r    <= eq_s;
               lt_r    <= lt_s;
               steps_r <= steps_r + CW'(1'b1);
               if (exit_s) begin
                  // Host-visible result changes only here; idx stays put
                  agb_r <= gt_s;
                  aeb_r <= eq_s;
                  alb_r <= lt_s;
               end else begin
                  idx_r <= idx_r - IW'(1'b1);
               end
            end
            DONE: begin
               done_r <= 1'b0;
            end
            default: begin
               done_r <= 1'b0;
            end
         endcase
      end
   end

   assign busy  = busy_r;
   assign done  = done_r;
   assign agb   = agb_r;
   assign aeb   = aeb_r;
   assign alb   = alb_r;
   assign steps = steps_r;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_compare_ctrl
// Two instances share operands: index 0 has EARLY_EXIT=1, index 1 has
// EARLY_EXIT=0. A reference model predicts acceptance, latency, flags and step
// counts; expectations are queued and a negedge monitor checks them.
// -----------------------------------------------------------------------------
module tb_serial_compare_ctrl;

   typedef struct {
      logic [2:0] flags;   // {gt, eq, lt}
      int         steps;
      int         due;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [7:0] a;
   logic [7:0] b;
   logic [1:0] start_v;
   logic [1:0] busy_v;
   logic [1:0] done_v;
   logic [1:0] agb_v;
   logic [1:0] aeb_v;
   logic [1:0] alb_v;
   logic [3:0] steps_v [2];

   int   cyc;
   int   n_tests;
   int   n_fail;
   bit   mon_en;
   exp_t q0[$];
   exp_t q1[$];
   int   free_at   [2];
   int   busy_from [2];
   logic [2:0] last_flags [2];

   serial_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_dut_ee (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a), .b(b),
      .busy(busy_v[0]), .done(done_v[0]), .agb(agb_v[0]), .aeb(aeb_v[0]),
      .alb(alb_v[0]), .steps(steps_v[0])
   );

   serial_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_dut_full (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a), .b(b),
      .busy(busy_v[1]), .done(done_v[1]), .agb(agb_v[1]), .aeb(aeb_v[1]),
      .alb(alb_v[1]), .steps(steps_v[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: steps needed for a compare of x against y
   function automatic int ref_steps(input bit early, input logic [7:0] x, input logic [7:0] y);
      if (!early || x == y) return 8;
      for (int i = 7; i >= 0; i--) begin
         if (x[i] != y[i]) return 8 - i;
      end
      return 8;
   endfunction

   task automatic chk(input string nm, input int k, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s[%0d] cyc=%0d got %0h expected %0h", nm, k, cyc, act, exp);
      end
   endtask

   task automatic fail_now(input string nm, input int k);
      n_tests++;
      n_fail++;
      $display("FAIL %s[%0d] cyc=%0d got event expected none", nm, k, cyc);
   endtask

   // Monitor body for one instance
   task automatic mon_inst(input int k);
      exp_t e;
      bit   have;
      have = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
      if (have) e = (k == 0) ? q0[0] : q1[0];
      chk("busy", k, int'(busy_v[k]), int'(cyc >= busy_from[k] && cyc < free_at[k]));
      if (done_v[k]) begin
         if (!have) begin
            fail_now("unexpected_done", k);
         end else begin
            if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            chk("done_cycle", k, cyc, e.due);
            chk("steps", k, int'(steps_v[k]), e.steps);
            last_flags[k] = e.flags;
         end
      end else if (have && e.due <= cyc) begin
         fail_now("done_missing", k);
         if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
      chk("flags", k, int'({agb_v[k], aeb_v[k], alb_v[k]}), int'(last_flags[k]));
   endtask

   // Scoreboard check of both instances, away from the active edge
   always @(negedge clk) begin
      if (mon_en) begin
         for (int k = 0; k < 2; k++) mon_inst(k);
      end
   end

   // One cycle of stimulus; the model decides acceptance per instance
   task automatic drive(input bit s0, input bit s1, input logic [7:0] av, input logic [7:0] bv);
      exp_t e;
      bit   st [2];
      int   c0;
      @(negedge clk);
      #1;
      a       = av;
      b       = bv;
      start_v = {s1, s0};
      st[0]   = s0;
      st[1]   = s1;
      for (int k = 0; k < 2; k++) begin
         if (st[k] && cyc >= free_at[k]) begin
            c0      = cyc + 1;
            e.flags = {av > bv, av == bv, av < bv};
            e.steps = ref_steps(k == 0, av, bv);
            e.due   = c0 + e.steps;
            busy_from[k] = c0;
            free_at[k]   = c0 + e.steps + 1;
            if (k == 0) q0.push_back(e); else q1.push_back(e);
         end
      end
   endtask

   task automatic idle_until_free();
      for (int n = 0; n < 40; n++) begin
         if (cyc >= free_at[0] && cyc >= free_at[1] && q0.size() == 0 && q1.size() == 0) return;
         drive(1'b0, 1'b0, 8'h00, 8'h00);
      end
      fail_now("timeout_idle", 0);
   endtask

   task automatic do_reset(input int ncyc);
      @(negedge clk);
      #1;
      rst_n   = 1'b0;
      start_v = 2'b00;
      q0.delete();
      q1.delete();
      for (int k = 0; k < 2; k++) begin
         free_at[k]    = 0;
         busy_from[k]  = 0;
         last_flags[k] = 3'b010;
      end
      repeat (ncyc) @(negedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [7:0] ra;
      logic [7:0] rb;
      n_tests = 0;
      n_fail  = 0;
      cyc     = 0;
      mon_en  = 1'b0;
      rst_n   = 1'b0;
      start_v = 2'b00;
      a       = 8'h00;
      b       = 8'h00;
      for (int k = 0; k < 2; k++) begin
         free_at[k]    = 0;
         busy_from[k]  = 0;
         last_flags[k] = 3'b010;
      end

      // Reset held for two edges, then reset values are checked
      repeat (2) @(posedge clk);
      mon_en = 1'b1;
      @(negedge clk);
      #1;
      chk("reset_steps", 0, int'(steps_v[0]), 0);
      chk("reset_steps", 1, int'(steps_v[1]), 0);
      chk("reset_done", 0, int'(done_v), 0);
      rst_n = 1'b1;

      // Directed compares
      drive(1'b1, 1'b1, 8'hA5, 8'h25);
      idle_until_free();
      drive(1'b1, 1'b1, 8'h3C, 8'h3C);
      idle_until_free();
      drive(1'b1, 1'b1, 8'h00, 8'h01);
      idle_until_free();

      // Start held high with changing operands: only idle-time starts count
      for (int n = 0; n < 24; n++) drive(1'b1, 1'b1, 8'($urandom), 8'($urandom));
      idle_until_free();

      // Reset on the third step of a running compare
      drive(1'b1, 1'b1, 8'hF0, 8'h0F);
      drive(1'b0, 1'b0, 8'h00, 8'h00);
      drive(1'b0, 1'b0, 8'h00, 8'h00);
      drive(1'b0, 1'b0, 8'h00, 8'h00);
      do_reset(1);
      drive(1'b0, 1'b0, 8'h00, 8'h00);
      drive(1'b1, 1'b1, 8'h81, 8'h82);
      idle_until_free();

      // Random traffic with biased operand relations
      for (int n = 0; n < 400; n++) begin
         ra = 8'($urandom);
         case ($urandom_range(0, 3))
            0:       rb = ra;
            1:       rb = ra ^ (8'h01 << $urandom_range(0, 7));
            default: rb = 8'($urandom);
         endcase
         drive(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0), ra, rb);
      end
      idle_until_free();
      drive(1'b0, 1'b0, 8'h00, 8'h00);
      chk("queue_drained", 0, q0.size(), 0);
      chk("queue_drained", 1, q1.size(), 0);

      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
